// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared types for the 5-stage hazard controller. Holds the
//                FSM state encodings, the default register index width and
//                the stall/flush control bundle with its canned patterns.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    // Default register index width for a 32-entry register file
    localparam int HZ_REG_ADDR_WIDTH = 5;

    // Controller state, also exported on state_o
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_HALT     = 2'd2
    } hz_state_e;

    // Per-stage stall/flush bundle, most significant field first
    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } hz_ctrl_t;

    // Nothing held, nothing squashed
    localparam hz_ctrl_t HZ_CTRL_NONE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Whole pipe held; MEM/WB gets a bubble so WB does not retire twice
    localparam hz_ctrl_t HZ_CTRL_FREEZE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    // Taken branch in EX: squash the two younger instructions
    localparam hz_ctrl_t HZ_CTRL_REDIR  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Load-use: hold PC and IF/ID, insert a bubble into EX
    localparam hz_ctrl_t HZ_CTRL_LDUSE  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // While reset is held every stage register loads a bubble
    localparam hz_ctrl_t HZ_CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_cnt
//  Description : Two independent enabled wrap-around event counters used for
//                stall-cycle and redirect-flush statistics. Only instantiated
//                when HAZARD_PERF_CNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_a,
    input  logic             en_b,
    output logic [WIDTH-1:0] cnt_a,
    output logic [WIDTH-1:0] cnt_b
);

    // Count enabled cycles; natural wrap on overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (en_a) cnt_a <= cnt_a + WIDTH'(1);
            if (en_b) cnt_b <= cnt_b + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush generator for the 5-stage core. Detects load-use
//                hazards, squashes on EX redirects, freezes the pipe while a
//                data access is outstanding and halts on a memory watchdog
//                timeout. Optional perf counters under HAZARD_PERF_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = HZ_REG_ADDR_WIDTH,
    parameter int MEM_TIMEOUT    = 256,
    parameter int TMO_CNT_WIDTH  = $clog2(MEM_TIMEOUT)
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_CNT_WIDTH = 32
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    input  logic                      rs1_used_id,
    input  logic                      rs2_used_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
    input  logic                      mem_read_ex,
    input  logic                      redirect_ex,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      stall_pc,
    output logic                      stall_if_id,
    output logic                      stall_id_ex,
    output logic                      stall_ex_mem,
    output logic                      flush_if_id,
    output logic                      flush_id_ex,
    output logic                      flush_mem_wb,
    output logic                      mem_timeout_err,
    output logic [1:0]                state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] stall_cyc_cnt_o,
    output logic [PERF_CNT_WIDTH-1:0] flush_evt_cnt_o
`endif
);

    // Watchdog fires when the counter reaches this value while still frozen
    localparam logic [TMO_CNT_WIDTH-1:0] C_TMO_LAST = TMO_CNT_WIDTH'(MEM_TIMEOUT - 1);

    hz_state_e                state;
    hz_state_e                state_nxt;
    logic [TMO_CNT_WIDTH-1:0] tmo_cnt;
    logic [TMO_CNT_WIDTH-1:0] tmo_cnt_nxt;
    logic                     err;
    hz_ctrl_t                 ctrl;
    logic                     frz;
    logic                     lu;

    assign frz = mem_req & ~mem_ready;

    // A load in EX whose destination feeds a live source of the ID instruction
    assign lu = mem_read_ex && (rd_ex != '0) &&
                ((rs1_used_id && (rs1_id == rd_ex)) ||
                 (rs2_used_id && (rs2_id == rd_ex)));

    // State, watchdog counter and sticky error register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= HZ_RUN;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            err     <= err | (state_nxt == HZ_HALT);
        end
    end

    // Next-state logic and Mealy stall/flush controls
    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        ctrl        = HZ_CTRL_NONE;
        unique case (state)
            HZ_RUN, HZ_MEM_WAIT: begin
                if (frz) begin
                    ctrl = HZ_CTRL_FREEZE;
                    if (state == HZ_RUN) begin
                        state_nxt   = HZ_MEM_WAIT;
                        tmo_cnt_nxt = TMO_CNT_WIDTH'(1);
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + TMO_CNT_WIDTH'(1);
                        if (tmo_cnt == C_TMO_LAST) state_nxt = HZ_HALT;
                    end
                end else begin
                    // Freeze released (or never present): normal hazard rules
                    if (redirect_ex)  ctrl = HZ_CTRL_REDIR;
                    else if (lu)      ctrl = HZ_CTRL_LDUSE;
                    state_nxt   = HZ_RUN;
                    tmo_cnt_nxt = '0;
                end
            end
            HZ_HALT: begin
                ctrl = HZ_CTRL_FREEZE;
            end
            default: begin
                state_nxt   = HZ_RUN;
                tmo_cnt_nxt = '0;
            end
        endcase
        // Reset overrides everything so stage registers fill with bubbles
        if (rst) ctrl = HZ_CTRL_RESET;
    end

    assign stall_pc        = ctrl.stall_pc;
    assign stall_if_id     = ctrl.stall_if_id;
    assign stall_id_ex     = ctrl.stall_id_ex;
    assign stall_ex_mem    = ctrl.stall_ex_mem;
    assign flush_if_id     = ctrl.flush_if_id;
    assign flush_id_ex     = ctrl.flush_id_ex;
    assign flush_mem_wb    = ctrl.flush_mem_wb;
    assign mem_timeout_err = err;
    assign state_o         = state;

`ifdef HAZARD_PERF_CNT_EN
    // flush_if_id outside reset only ever comes from a redirect
    logic redir_flush;
    assign redir_flush = ctrl.flush_if_id & ~rst;

    hazard_perf_cnt #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_a  (ctrl.stall_pc),
        .en_b  (redir_flush),
        .cnt_a (stall_cyc_cnt_o),
        .cnt_b (flush_evt_cnt_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl, built
//                with a 4-cycle memory watchdog. Perf counter checks are
//                included when HAZARD_PERF_CNT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_id = '0;
    logic [4:0] rs2_id = '0;
    logic       rs1_used_id = 1'b0;
    logic       rs2_used_id = 1'b0;
    logic [4:0] rd_ex = '0;
    logic       mem_read_ex = 1'b0;
    logic       redirect_ex = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic       flush_if_id, flush_id_ex, flush_mem_wb;
    logic       mem_timeout_err;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cyc_cnt_o;
    logic [31:0] flush_evt_cnt_o;
`endif

    // Expected control patterns: {stall_pc,if_id,id_ex,ex_mem,flush_if_id,id_ex,mem_wb}
    localparam logic [6:0] E_NONE = 7'b0000_000;
    localparam logic [6:0] E_FRZ  = 7'b1111_001;
    localparam logic [6:0] E_LU   = 7'b1100_010;
    localparam logic [6:0] E_RDR  = 7'b0000_110;
    localparam logic [6:0] E_RST  = 7'b0000_111;

    int checks = 0;
    int errors = 0;

    logic [6:0] ctl;
    assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  flush_if_id, flush_id_ex, flush_mem_wb};

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_ex           (rd_ex),
        .mem_read_ex     (mem_read_ex),
        .redirect_ex     (redirect_ex),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .stall_id_ex     (stall_id_ex),
        .stall_ex_mem    (stall_ex_mem),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .flush_mem_wb    (flush_mem_wb),
        .mem_timeout_err (mem_timeout_err),
        .state_o         (state_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cyc_cnt_o (stall_cyc_cnt_o),
        .flush_evt_cnt_o (flush_evt_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Move to the next falling edge, return all ID/EX inputs to idle
    task automatic idle_cycle();
        @(negedge clk);
        rs1_id = '0; rs2_id = '0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
        rd_ex = '0; mem_read_ex = 1'b0; redirect_ex = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        // Reset state, with reset held
        #2;
        chk("rst_ctl",   32'(ctl), 32'(E_RST));
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_err",   32'(mem_timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_ctl", 32'(ctl), 32'(E_NONE));

        // Load-use on rs1
        idle_cycle();
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        #1 chk("lu_rs1", 32'(ctl), 32'(E_LU));
        // Bubble now in EX
        idle_cycle();
        rs1_id = 5'd5; rs1_used_id = 1'b1;
        #1 chk("lu_bubble", 32'(ctl), 32'(E_NONE));
        // rd_ex == 0 never hazards
        idle_cycle();
        mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1;
        #1 chk("lu_x0", 32'(ctl), 32'(E_NONE));
        // rs2 match but rs2 not read
        idle_cycle();
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b0;
        #1 chk("lu_unused", 32'(ctl), 32'(E_NONE));
        // Load-use on rs2
        idle_cycle();
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b1;
        #1 chk("lu_rs2", 32'(ctl), 32'(E_LU));
        // Non-load producer does not stall
        idle_cycle();
        mem_read_ex = 1'b0; rd_ex = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b1;
        #1 chk("no_load", 32'(ctl), 32'(E_NONE));

        // Redirect beats load-use
        idle_cycle();
        mem_read_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; rs1_used_id = 1'b1; redirect_ex = 1'b1;
        #1 chk("redir_lu", 32'(ctl), 32'(E_RDR));

        // Ready with no request is ignored
        idle_cycle();
        mem_ready = 1'b1;
        #1 chk("ready_noreq", 32'(ctl), 32'(E_NONE));

        // Three-cycle memory wait
        idle_cycle();
        mem_req = 1'b1;
        #1 chk("w1_ctl", 32'(ctl), 32'(E_FRZ));
        chk("w1_state", 32'(state_o), 32'd0);
        @(negedge clk);
        #1 chk("w2_ctl", 32'(ctl), 32'(E_FRZ));
        chk("w2_state", 32'(state_o), 32'd1);
        @(negedge clk);
        #1 chk("w3_ctl", 32'(ctl), 32'(E_FRZ));
        chk("w3_state", 32'(state_o), 32'd1);
        @(negedge clk);
        mem_ready = 1'b1;
        #1 chk("wrel_ctl", 32'(ctl), 32'(E_NONE));
        chk("wrel_state", 32'(state_o), 32'd1);
        idle_cycle();
        #1 chk("wdone_state", 32'(state_o), 32'd0);
        chk("wdone_ctl", 32'(ctl), 32'(E_NONE));
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", stall_cyc_cnt_o, 32'd5);
        chk("perf_flush", flush_evt_cnt_o, 32'd1);
`endif

        // Redirect arriving while frozen fires once, on release
        idle_cycle();
        mem_req = 1'b1; redirect_ex = 1'b1;
        #1 chk("rf_frz", 32'(ctl), 32'(E_FRZ));
        @(negedge clk);
        mem_ready = 1'b1;
        #1 chk("rf_rel", 32'(ctl), 32'(E_RDR));
        idle_cycle();
        #1 chk("rf_after", 32'(ctl), 32'(E_NONE));
        chk("rf_state", 32'(state_o), 32'd0);

        // Async reset mid-wait, between clock edges
        idle_cycle();
        mem_req = 1'b1;
        @(negedge clk);
        #1 chk("ar_pre", 32'(state_o), 32'd1);
        #1 rst = 1'b1;
        #1 chk("ar_state", 32'(state_o), 32'd0);
        chk("ar_err", 32'(mem_timeout_err), 32'd0);
        chk("ar_ctl", 32'(ctl), 32'(E_RST));
        rst = 1'b0;
        #1 chk("ar_after", 32'(ctl), 32'(E_FRZ));
        idle_cycle();

        // Watchdog: four frozen cycles then HALT
        idle_cycle();
        mem_req = 1'b1;
        #1 chk("wd1_state", 32'(state_o), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            #1 chk($sformatf("wd%0d_state", i), 32'(state_o), 32'd1);
        end
        chk("wd4_err", 32'(mem_timeout_err), 32'd0);
        @(negedge clk);
        #1 chk("wd_halt", 32'(state_o), 32'd2);
        chk("wd_err", 32'(mem_timeout_err), 32'd1);
        chk("wd_ctl", 32'(ctl), 32'(E_FRZ));
        mem_ready = 1'b1;
        #1 chk("halt_rdy_ctl", 32'(ctl), 32'(E_FRZ));
        idle_cycle();
        redirect_ex = 1'b1;
        #1 chk("halt_stay", 32'(state_o), 32'd2);
        chk("halt_ctl", 32'(ctl), 32'(E_FRZ));
        chk("halt_err", 32'(mem_timeout_err), 32'd1);
        // Only reset leaves HALT
        #1 rst = 1'b1;
        #1 chk("halt_rst_state", 32'(state_o), 32'd0);
        chk("halt_rst_err", 32'(mem_timeout_err), 32'd0);
        idle_cycle();
        rst = 1'b0;
        #1 chk("final_ctl", 32'(ctl), 32'(E_NONE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Generates the per-stage stall/flush controls for the 5-stage core. It is the driving end of the flush input on the ID/EX pipeline register and of the matching controls on IF/ID, EX/MEM and MEM/WB.
- Consumes decode source registers and EX-stage destination/control, branch redirect from EX, and the data-memory req/ready handshake.
- Resolves load-use bubbles, taken-branch squashes and multi-cycle memory freezes. A watchdog halts the pipe if memory never responds.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- MEM_TIMEOUT, 256, max consecutive wait cycles before HALT; legal range 2..65536.
- TMO_CNT_WIDTH, $clog2(MEM_TIMEOUT), watchdog counter width.
- PERF_CNT_WIDTH, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rs1_id  in  REG_ADDR_WIDTH  rs1 of instr in ID
- rs2_id  in  REG_ADDR_WIDTH  rs2 of instr in ID
- rs1_used_id  in  1  ID instr reads rs1
- rs2_used_id  in  1  ID instr reads rs2
- rd_ex  in  REG_ADDR_WIDTH  rd of instr in EX
- mem_read_ex  in  1  EX instr is a load
- redirect_ex  in  1  EX resolved taken branch/jal/jalr
- mem_req  in  1  MEM-stage data access outstanding
- mem_ready  in  1  data memory completes access this cycle
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  hold stage register
- flush_if_id, flush_id_ex, flush_mem_wb  out  1 each  load bubble (sampled at next posedge)
- mem_timeout_err  out  1  sticky watchdog error
- state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, HALT=2

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Controls are Mealy-combinational from state and inputs; the stage registers sample them at the next posedge. Only the state, watchdog counter and error bit are registered.
- frz = mem_req & ~mem_ready.
- lu = mem_read_ex & (rd_ex!=0) & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- RUN, priority high to low:
  - frz: all four stall_* = 1 and flush_mem_wb = 1; next state MEM_WAIT, counter <= 1.
  - redirect_ex: flush_if_id = 1 and flush_id_ex = 1, no stall. Redirect beats lu.
  - lu: stall_pc = 1, stall_if_id = 1, flush_id_ex = 1 for exactly one cycle. The following cycle re-evaluates with a bubble in EX, so lu = 0.
  - Otherwise all outputs 0.
- MEM_WAIT:
  - frz: same freeze outputs; counter increments. If counter == MEM_TIMEOUT-1, next state HALT.
  - ~frz: freeze released this cycle. RUN's redirect/lu rules are applied this same cycle; next state RUN, counter <= 0.
  - redirect_ex arriving while frozen is not acted on until the freeze releases. EX is held, so the signal persists and the redirect fires exactly once.
- HALT: all stalls = 1, flush_mem_wb = 1, mem_timeout_err = 1. The block leaves HALT only on rst; mem_ready is ignored.
- Reset, asserted at any time including mid-wait:
  - state <= RUN, counter <= 0, mem_timeout_err <= 0 immediately.
  - While rst is high: stall_* = 0; flush_if_id, flush_id_ex, flush_mem_wb = 1; state_o = 0.
- rd_ex == 0 never triggers lu. mem_req = 0 with mem_ready = 1 is legal and ignored.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cyc_cnt_o and flush_evt_cnt_o, each PERF_CNT_WIDTH wide, reset to 0, wrapping on overflow.
  - stall_cyc_cnt_o: +1 per cycle with stall_pc = 1.
  - flush_evt_cnt_o: +1 per cycle with redirect-driven flush_if_id = 1.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared include.v: state encodings HZ_RUN, HZ_MEM_WAIT, HZ_HALT and the REG_ADDR_WIDTH default.
- One sub-module, hazard_perf_cnt (two enabled wrap counters), instantiated only under HAZARD_PERF_CNT_EN.
- Comparator and FSM stay in the top.

Test Plan:
1. Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> one cycle of stall_pc=stall_if_id=flush_id_ex=1; same setup with rd_ex=0 -> all outputs 0.
2. Redirect plus lu in the same cycle -> flush_if_id=flush_id_ex=1, stall_pc=0.
3. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready -> freeze for 3 cycles, state_o 0->1->1->1->0, outputs 0 on the ready cycle.
4. Watchdog with MEM_TIMEOUT=4: mem_req=1 held, never ready -> state_o=2 and mem_timeout_err=1 after 4 frozen cycles; later mem_ready=1 -> still HALT.
5. Async rst pulse mid MEM_WAIT, between clock edges -> state_o=0 and err=0 immediately; during rst flushes=1, stalls=0.
6. HAZARD_PERF_CNT_EN: 2 load-use events plus 3 wait cycles -> stall_cyc_cnt_o=5; 1 redirect -> flush_evt_cnt_o=1.
